// File: rtl/dm_cache_ctrl.sv
// Purpose: direct-mapped, write-through, no-write-allocate data cache with burst line refill.
// Latency: read hit 2 cycles; read miss 2 + refill-request wait + WORDS beats + 1; write 2 + write-ack wait + 1.
// Backpressure: req_ready only in IDLE (one request outstanding); mem valids hold until ready; no response backpressure.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_*                    CPU request (valid/ready), word address {tag, index, offset}
//   flush                    invalidate all lines; honoured only in IDLE
//   resp_*                   one-cycle registered response pulse with data and hit flag
//   mem_rd_* / mem_rdata*    line refill request and WORDS data beats (offset 0 first)
//   mem_wr_*                 single-word write-through request
//   hit_count, miss_count    saturating statistics, present only when CACHE_STATS_EN is defined
module dm_cache_ctrl #(
    parameter  int TAG_W   = 3,
    parameter  int INDEX_W = 10,
    parameter  int OFF_W   = 2,
    parameter  int DATA_W  = 32,
    localparam int ADDR_W  = TAG_W + INDEX_W + OFF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              flush,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_hit,
    output logic              mem_rd_valid,
    input  logic              mem_rd_ready,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rdata_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << OFF_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_REFILL,
        S_WR_THRU,
        S_RESP
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                hit_q;
    logic [OFF_W-1:0]    beat_q;
    logic [LINES-1:0]    valid_q;

    logic                resp_valid_q;
    logic [DATA_W-1:0]   resp_data_q;
    logic                resp_hit_q;
    logic                mem_rd_valid_q;
    logic [ADDR_W-1:0]   mem_rd_addr_q;
    logic                mem_wr_valid_q;
    logic [ADDR_W-1:0]   mem_wr_addr_q;
    logic [DATA_W-1:0]   mem_wr_data_q;

    // Tag and data storage carry no reset; only the valid bits define contents.
    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [DATA_W-1:0]   data_mem [LINES*WORDS];

    logic [TAG_W-1:0]    tag_f;
    logic [INDEX_W-1:0]  idx_f;
    logic [OFF_W-1:0]    off_f;
    logic                lookup_hit;
    logic [DATA_W-1:0]   lookup_word;

    logic                data_we_d;
    logic [INDEX_W+OFF_W-1:0] data_waddr_d;
    logic [DATA_W-1:0]   data_wdat_d;
    logic                tag_we_d;
    logic                last_beat;

    assign tag_f = addr_q[ADDR_W-1 -: TAG_W];
    assign idx_f = addr_q[OFF_W +: INDEX_W];
    assign off_f = addr_q[OFF_W-1:0];

    assign lookup_hit  = valid_q[idx_f] && (tag_mem[idx_f] == tag_f);
    assign lookup_word = data_mem[{idx_f, off_f}];
    assign last_beat   = &beat_q;

    // Flush takes the IDLE cycle, so no request may be accepted alongside it.
    assign req_ready = (state_q == S_IDLE) && !flush && !rst;

    // Storage writes: write hit in LOOKUP, or one refill beat per valid cycle in REFILL.
    always_comb begin
        data_we_d    = 1'b0;
        data_waddr_d = {idx_f, off_f};
        data_wdat_d  = wdata_q;
        if (!rst) begin
            if (state_q == S_LOOKUP && we_q && lookup_hit) begin
                data_we_d = 1'b1;
            end else if (state_q == S_REFILL && mem_rdata_valid) begin
                data_we_d    = 1'b1;
                data_waddr_d = {idx_f, beat_q};
                data_wdat_d  = mem_rdata;
            end
        end
    end

    assign tag_we_d = !rst && (state_q == S_REFILL) && mem_rdata_valid && last_beat;

    always_ff @(posedge clk) begin
        if (data_we_d) begin
            data_mem[data_waddr_d] <= data_wdat_d;
        end
        if (tag_we_d) begin
            tag_mem[idx_f] <= tag_f;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            we_q           <= 1'b0;
            wdata_q        <= '0;
            hit_q          <= 1'b0;
            beat_q         <= '0;
            valid_q        <= '0;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= '0;
            resp_hit_q     <= 1'b0;
            mem_rd_valid_q <= 1'b0;
            mem_rd_addr_q  <= '0;
            mem_wr_valid_q <= 1'b0;
            mem_wr_addr_q  <= '0;
            mem_wr_data_q  <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (flush) begin
                        valid_q <= '0;
                    end else if (req_valid) begin
                        addr_q  <= req_addr;
                        we_q    <= req_we;
                        wdata_q <= req_wdata;
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    hit_q <= lookup_hit;
                    if (we_q) begin
                        // Write-through on hit and miss; a miss leaves the line alone.
                        resp_data_q    <= '0;
                        mem_wr_valid_q <= 1'b1;
                        mem_wr_addr_q  <= addr_q;
                        mem_wr_data_q  <= wdata_q;
                        state_q        <= S_WR_THRU;
                    end else if (lookup_hit) begin
                        resp_data_q <= lookup_word;
                        state_q     <= S_RESP;
                    end else begin
                        mem_rd_valid_q <= 1'b1;
                        mem_rd_addr_q  <= {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        beat_q         <= '0;
                        state_q        <= S_MISS_REQ;
                    end
                end
                S_MISS_REQ: begin
                    if (mem_rd_ready) begin
                        mem_rd_valid_q <= 1'b0;
                        state_q        <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (mem_rdata_valid) begin
                        beat_q <= beat_q + OFF_W'(1);
                        if (beat_q == off_f) begin
                            resp_data_q <= mem_rdata;
                        end
                        if (last_beat) begin
                            valid_q[idx_f] <= 1'b1;
                            state_q        <= S_RESP;
                        end
                    end
                end
                S_WR_THRU: begin
                    if (mem_wr_ready) begin
                        mem_wr_valid_q <= 1'b0;
                        state_q        <= S_RESP;
                    end
                end
                S_RESP: begin
                    // Response is registered out of RESP, landing in the first IDLE cycle.
                    resp_valid_q <= 1'b1;
                    resp_hit_q   <= hit_q;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;
    assign resp_hit     = resp_hit_q;
    assign mem_rd_valid = mem_rd_valid_q;
    assign mem_rd_addr  = mem_rd_addr_q;
    assign mem_wr_valid = mem_wr_valid_q;
    assign mem_wr_addr  = mem_wr_addr_q;
    assign mem_wr_data  = mem_wr_data_q;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // One count per request, taken in its LOOKUP cycle; saturates, survives flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == S_LOOKUP) begin
            if (lookup_hit) begin
                if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
`timescale 1ns/1ps
module tb_dm_cache_ctrl;
    localparam int TAG_W   = 3;
    localparam int INDEX_W = 10;
    localparam int OFF_W   = 2;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = TAG_W + INDEX_W + OFF_W;
    localparam int WORDS   = 1 << OFF_W;
    localparam int LINES   = 1 << INDEX_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, req_valid, req_ready, req_we, flush;
    logic [ADDR_W-1:0] req_addr, mem_rd_addr, mem_wr_addr;
    logic [DATA_W-1:0] req_wdata, resp_data, mem_rdata, mem_wr_data;
    logic              resp_valid, resp_hit, mem_rd_valid, mem_rd_ready;
    logic              mem_rdata_valid, mem_wr_valid, mem_wr_ready;
`ifdef CACHE_STATS_EN
    logic [31:0]       hit_count, miss_count;
`endif

    dm_cache_ctrl #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .OFF_W(OFF_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
        .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: backing memory plus per-line valid/tag. Because the cache is
    // write-through and no-write-allocate, any valid line mirrors memory, so the
    // expected read data is always the backing memory word.
    logic [DATA_W-1:0] mem_model [1 << ADDR_W];
    bit                m_valid   [LINES];
    logic [TAG_W-1:0]  m_tag     [LINES];
    int                m_hits, m_misses;

    // Observations from the last request
    logic [DATA_W-1:0] r_data;
    logic              r_hit;
    int                r_lat, r_rd_hs, r_wr_cyc;
    bit                r_timeout, r_rd_unstable, r_wr_unstable, r_busy_ready;
    logic [ADDR_W-1:0] r_rd_addr, r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_req_ready"},    req_ready,    0);
        check({pfx, "_resp_valid"},   resp_valid,   0);
        check({pfx, "_resp_data"},    resp_data,    0);
        check({pfx, "_resp_hit"},     resp_hit,     0);
        check({pfx, "_mem_rd_valid"}, mem_rd_valid, 0);
        check({pfx, "_mem_wr_valid"}, mem_wr_valid, 0);
        check({pfx, "_mem_rd_addr"},  mem_rd_addr,  0);
        check({pfx, "_mem_wr_addr"},  mem_wr_addr,  0);
        check({pfx, "_mem_wr_data"},  mem_wr_data,  0);
`ifdef CACHE_STATS_EN
        check({pfx, "_hit_count"},    hit_count,    0);
        check({pfx, "_miss_count"},   miss_count,   0);
`endif
    endtask

    // Issue one request at a negedge in IDLE and act as the memory until the response.
    task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                          input int rd_wait, input int wr_wait, input int gap, input bit junk);
        int rd_cyc, wr_cyc, beats, idle;
        bit refill;
        logic [ADDR_W-1:0] base;
        rd_cyc = 0; wr_cyc = 0; beats = 0; idle = 0; refill = 0; base = '0;
        r_rd_hs = 0; r_rd_unstable = 0; r_wr_unstable = 0; r_busy_ready = 0;
        r_timeout = 1; r_lat = -1; r_data = 'x; r_hit = 1'bx;
        r_rd_addr = '0; r_wr_addr = '0; r_wr_data = '0;
        #1;
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        for (int t = 0; t < 300; t++) begin
            mem_rd_ready = 1'b0; mem_rdata_valid = 1'b0; mem_wr_ready = 1'b0; mem_rdata = '0;
            if (resp_valid) begin
                r_data = resp_data; r_hit = resp_hit; r_lat = t; r_timeout = 0;
                req_valid = 1'b0; flush = 1'b0;
                break;
            end
            if (req_ready) r_busy_ready = 1;
            // Requests and flushes offered while busy must be ignored.
            req_valid = junk; flush = junk && ($urandom_range(0, 1) == 1);
            req_addr = ADDR_W'($urandom); req_we = $urandom_range(0, 1) == 1; req_wdata = $urandom;
            if (junk && t == 0) begin
                mem_rdata_valid = 1'b1; mem_rdata = $urandom;
            end
            if (mem_rd_valid) begin
                if (rd_cyc == 0) r_rd_addr = mem_rd_addr;
                else if (mem_rd_addr !== r_rd_addr) r_rd_unstable = 1;
                rd_cyc++;
                if (rd_cyc > rd_wait) begin
                    mem_rd_ready = 1'b1; r_rd_hs++; refill = 1; base = mem_rd_addr; beats = 0; idle = 0;
                end
            end else if (refill && beats < WORDS) begin
                if (idle < gap) idle++;
                else begin
                    mem_rdata_valid = 1'b1; mem_rdata = mem_model[int'(base) + beats]; beats++; idle = 0;
                end
            end
            if (mem_wr_valid) begin
                if (wr_cyc == 0) begin r_wr_addr = mem_wr_addr; r_wr_data = mem_wr_data; end
                else if (mem_wr_addr !== r_wr_addr || mem_wr_data !== r_wr_data) r_wr_unstable = 1;
                wr_cyc++;
                if (wr_cyc > wr_wait) mem_wr_ready = 1'b1;
            end
            @(negedge clk);
        end
        r_wr_cyc = wr_cyc;
        req_valid = 1'b0; flush = 1'b0;
        mem_rd_ready = 1'b0; mem_rdata_valid = 1'b0; mem_wr_ready = 1'b0;
    endtask

    task automatic run_req(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                           input int rd_wait, input int wr_wait, input int gap, input bit junk);
        int idx, exp_lat;
        logic [TAG_W-1:0] tg;
        bit exp_hit;
        logic [DATA_W-1:0] exp_data;
        idx = int'(addr[OFF_W +: INDEX_W]);
        tg  = addr[ADDR_W-1 -: TAG_W];
        exp_hit  = m_valid[idx] && (m_tag[idx] == tg);
        exp_data = we ? '0 : mem_model[addr];
        if (exp_hit) m_hits++; else m_misses++;
        do_req(we, addr, wdata, rd_wait, wr_wait, gap, junk);
        check("timeout", r_timeout, 0);
        check("resp_hit", r_hit, exp_hit);
        check("resp_data", r_data, exp_data);
        check("busy_req_ready", r_busy_ready, 0);
        if (we) begin
            exp_lat = 3 + wr_wait;
            check("wr_cycles", r_wr_cyc, wr_wait + 1);
            check("wr_addr", r_wr_addr, addr);
            check("wr_data", r_wr_data, wdata);
            check("wr_stable", r_wr_unstable, 0);
            check("rd_reqs_on_write", r_rd_hs, 0);
            mem_model[addr] = wdata;
        end else if (exp_hit) begin
            exp_lat = 2;
            check("rd_reqs_on_hit", r_rd_hs, 0);
            check("wr_on_read", r_wr_cyc, 0);
        end else begin
            exp_lat = 2 + rd_wait + WORDS * (gap + 1) + 1;
            check("rd_reqs_on_miss", r_rd_hs, 1);
            check("rd_addr", r_rd_addr, {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}});
            check("rd_stable", r_rd_unstable, 0);
            check("wr_on_read", r_wr_cyc, 0);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
        end
        check("latency", r_lat, exp_lat);
    endtask

    task automatic do_flush();
        flush = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 15'h0001;
        #1;
        check("ready_during_flush", req_ready, 0);
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        #1;
        check("idle_after_flush", req_ready, 1);
        model_clear();
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; flush = 1'b0;
        mem_rd_ready = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = '0; mem_wr_ready = 1'b0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem_model[i] = $urandom;
        mem_model[0] = 32'd16; mem_model[1] = 32'd14; mem_model[2] = 32'd12; mem_model[3] = 32'd10;
        model_clear();
        m_hits = 0; m_misses = 0;

        // Reset
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        // Cold read, then hit in the same line
        run_req(1'b0, 15'h0001, '0, 0, 0, 0, 1'b0);
        check("cold_data_14", r_data, 32'd14);
        check("cold_rd_addr", r_rd_addr, 15'h0000);
        run_req(1'b0, 15'h0003, '0, 0, 0, 0, 1'b0);
        check("hit_data_10", r_data, 32'd10);
        check("hit_flag", r_hit, 1);

        // Tag conflict on index 0, then the original line misses again
        run_req(1'b0, 15'h1001, '0, 2, 0, 1, 1'b1);
        check("conflict_rd_addr", r_rd_addr, 15'h1000);
        run_req(1'b0, 15'h0001, '0, 1, 0, 0, 1'b0);
        check("conflict_remiss", r_hit, 0);

        // Write-through hit with a 3-cycle stall, then read back without refill
        run_req(1'b1, 15'h0002, 32'h0000_DEAD, 0, 3, 0, 1'b0);
        check("wt_valid_cycles", r_wr_cyc, 4);
        check("wt_hit", r_hit, 1);
        run_req(1'b0, 15'h0002, '0, 0, 0, 0, 1'b0);
        check("wt_readback", r_data, 32'h0000_DEAD);

        // Write miss leaves the line invalid
        run_req(1'b1, 15'h0010, 32'h0000_1234, 0, 1, 0, 1'b1);
        check("wmiss_hit", r_hit, 0);
        run_req(1'b0, 15'h0010, '0, 0, 0, 0, 1'b0);
        check("wmiss_line_invalid", r_hit, 0);

        // Flush then re-read
        do_flush();
        run_req(1'b0, 15'h0001, '0, 0, 0, 0, 1'b0);
        check("flush_remiss", r_hit, 0);

`ifdef CACHE_STATS_EN
        check("stats_hits_directed", hit_count, m_hits);
        check("stats_misses_directed", miss_count, m_misses);
`endif

        // Reset after 2 of 4 refill beats
        req_valid = 1'b1; req_we = 1'b0; req_addr = 15'h0005;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        check("mid_rd_valid", mem_rd_valid, 1);
        mem_rd_ready = 1'b1;
        @(negedge clk); mem_rd_ready = 1'b0;
        mem_rdata_valid = 1'b1; mem_rdata = mem_model[4];
        @(negedge clk); mem_rdata = mem_model[5];
        @(negedge clk); mem_rdata_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        rst = 1'b0;
        mem_rdata_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        check("late_beat_ignored_0", req_ready, 1);
        @(negedge clk);
        check("late_beat_ignored_1", resp_valid, 0);
        mem_rdata_valid = 1'b0;
        model_clear();
        m_hits = 0; m_misses = 0;
        run_req(1'b0, 15'h0005, '0, 0, 0, 0, 1'b0);
        check("midrst_remiss", r_hit, 0);

        // Randomised traffic over a small address pool
        for (int n = 0; n < 200; n++) begin
            logic [ADDR_W-1:0] a;
            logic [TAG_W-1:0]  tg;
            logic [INDEX_W-1:0] ix;
            logic [OFF_W-1:0]  of;
            tg = TAG_W'($urandom_range(0, 3));
            ix = INDEX_W'($urandom_range(0, 7));
            of = OFF_W'($urandom_range(0, 3));
            a  = {tg, ix, of};
            if ($urandom_range(0, 19) == 0) do_flush();
            run_req($urandom_range(0, 9) < 3, a, $urandom,
                    $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1),
                    $urandom_range(0, 1) == 1);
        end

`ifdef CACHE_STATS_EN
        check("stats_hits_final", hit_count, m_hits);
        check("stats_misses_final", miss_count, m_misses);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dm_cache_ctrl.md
# dm_cache_ctrl

Parametrised direct-mapped data cache with a valid/ready CPU request port and a burst refill/write-through memory port. It replaces the fixed-geometry, miss-data-fed cache used in the data path. Lines are refilled from memory one word per beat, and it adds write support, flush and registered responses. It sits between the core load/store unit and the memory controller.

## Interface
- TAG_W, 3, tag bits
- INDEX_W, 10, index bits; the cache holds 2**INDEX_W lines
- OFF_W, 2, word-offset bits; WORDS = 2**OFF_W words per line
- DATA_W, 32, word width
- Derived: ADDR_W = TAG_W+INDEX_W+OFF_W (default 15)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  CPU request valid
- req_ready  out  1  cache can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address: {tag, index, offset}
- req_wdata  in  DATA_W  write data
- flush  in  1  invalidate all lines
- resp_valid  out  1  one-cycle response pulse
- resp_data  out  DATA_W  read data (writes return 0)
- resp_hit  out  1  request hit
- mem_rd_valid  out  1  line-refill request
- mem_rd_ready  in  1  memory accepts refill request
- mem_rd_addr  out  ADDR_W  line base address; offset field = 0
- mem_rdata_valid  in  1  refill beat valid
- mem_rdata  in  DATA_W  refill beat, offset 0 first
- mem_wr_valid  out  1  write-through request
- mem_wr_ready  in  1  memory accepts write
- mem_wr_addr  out  ADDR_W  write word address
- mem_wr_data  out  DATA_W  write data
- hit_count, miss_count  out  32  statistics; present only with CACHE_STATS_EN

## Operation
- Storage:
  - Per line: valid bit (flops), tag, WORDS data words.
  - Hit = valid[index] && tag matches.
- FSM states: IDLE, LOOKUP, MISS_REQ, REFILL, WR_THRU, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr/we/wdata and go to LOOKUP.
  - If flush=1 in IDLE: all valid bits clear at the next edge. req_ready=0 during that cycle, so no request is accepted.
- LOOKUP:
  - Read hit → RESP, resp_hit=1.
  - Read miss → MISS_REQ.
  - Write, hit or miss → WR_THRU. A write hit also updates the stored word at this edge.
  - Writes are no-write-allocate: a write miss leaves the line untouched.
- MISS_REQ:
  - Hold mem_rd_valid with a stable mem_rd_addr until mem_rd_ready.
  - Then go to REFILL.
- REFILL:
  - Each mem_rdata_valid beat writes the word at beat counter k (0..WORDS-1), then k increments.
  - On the last beat, set valid and tag, capture the requested word, and go to RESP with resp_hit=0.
  - Gaps between beats are allowed.
- WR_THRU:
  - Hold mem_wr_valid/addr/data until mem_wr_ready.
  - Then go to RESP; resp_hit reflects the LOOKUP result.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - There is no response backpressure.
- flush is ignored outside IDLE. It is sampled again once the FSM returns to IDLE.

## Timing
- Reset:
  - At any clk edge with rst=1, state → IDLE and all valid bits → 0.
  - Reset values: req_ready=0 during reset, resp_valid=0, resp_data=0, resp_hit=0, mem_rd_valid=0, mem_wr_valid=0, mem_rd_addr=0, mem_wr_addr=0, mem_wr_data=0, counters=0.
  - Reset mid-refill or mid-write abandons the transaction. Partial line data is left but stays invalid. Beats that arrive after reset are ignored.
- Read hit: request accepted at edge N, resp_valid high during cycle N+2 → N+3. Latency is 2.
- Read miss latency: 2 + refill-request wait + WORDS beats + 1.
- Write latency: 2 + write-ack wait + 1.
- req_ready=0 in every state except IDLE, so only one request is outstanding.
- mem_*_valid, once asserted, stays high with stable addr/data until the ready handshake completes.
- Refill: mem_rdata_valid outside REFILL is ignored. Exactly WORDS beats are consumed per refill.

## Configuration
- CACHE_STATS_EN defined:
  - hit_count and miss_count ports exist.
  - Each counter increments by 1 in the LOOKUP cycle, for reads and writes.
  - Counters saturate at 2^32-1 and clear on rst.
  - flush does not clear them.
- CACHE_STATS_EN undefined: no counter ports and no counter logic.

## Test plan
- Cold read:
  - Stimulus: rst, then read addr 0x0001 with mem_rd_ready=1; beats 16,14,12,10 for offsets 0..3.
  - Required: mem_rd_addr=0x0000; resp_data=14, resp_hit=0.
- Read hit after the cold read:
  - Stimulus: read 0x0003.
  - Required: resp_data=10, resp_hit=1, resp_valid exactly 2 cycles after acceptance, no mem_rd_valid.
- Tag conflict:
  - Stimulus: read 0x1001 (same index, tag 1).
  - Required: refill from 0x1000; the following read of 0x0001 misses again.
- Write-through:
  - Stimulus: write 0x0002=0xDEAD (hit) with mem_wr_ready stalled 3 cycles.
  - Required: mem_wr_valid held 4 cycles with stable addr/data, resp_hit=1; a later read of 0x0002 returns 0xDEAD with no refill.
- Write miss:
  - Stimulus: write to an uncached index.
  - Required: resp_hit=0; the line stays invalid.
- Flush and reset:
  - Flush in IDLE, then re-read 0x0001 → miss.
  - Assert rst after 2 of 4 refill beats → outputs at reset values next cycle; a re-read misses.
  - With CACHE_STATS_EN, counters match the hit/miss sequence.
